// File: rtl/odd_pipe_pkg.sv
`timescale 1ns/1ps
// Shared opcode enum, result-packet layout and unit/latency/mask constants
// for the odd execution pipe (package descriptions).
package descriptions;

  typedef enum logic [5:0] {
    NOP, SHLQBI, SHLQBII, SHLQBY, SHLQBYI, SHLQBYBI,
    ROTQBY, ROTQBYI, ROTQBYBI, ROTQBI, ROTQBII,
    GBB, GBH, GB,
    LQD, LQA, STQD, STQA,
    BR, BRA, BRSL, BRASL, BRZ, BRNZ, BRHZ, BRHNZ
  } op_e;

  // Declared MSB first, so field order matches the bit-0-is-MSB packet map.
  typedef struct packed {
    logic [127:0] result;
    logic [6:0]   rt;
    logic         wr_en;
    logic [2:0]   unit;
    logic [3:0]   lat;
  } pkt_t;

  localparam int PKT_W = 143;

  localparam logic [2:0] UNIT_NONE = 3'd0;
  localparam logic [2:0] UNIT_PERM = 3'd1;
  localparam logic [2:0] UNIT_LS   = 3'd2;
  localparam logic [2:0] UNIT_BR   = 3'd3;

  localparam logic [3:0] LAT_PERM = 4'd4;
  localparam logic [3:0] LAT_LS   = 4'd6;
  localparam logic [3:0] LAT_BR   = 4'd1;

  localparam logic [31:0] LS_MASK = 32'h0000_7FF0;
  localparam logic [31:0] BR_MASK = 32'h0000_7FFC;

  function automatic logic [31:0] sext10(input logic [9:0] v);
    return {{22{v[9]}}, v};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/odd_pipe_permute_unit.sv
`timescale 1ns/1ps
// Combinational quadword shift/rotate datapath; gather-bits ops exist only
// when ODD_GATHER_BITS_EN is defined.
module odd_permute_unit
  import descriptions::*;
(
  input  op_e          op,
  input  logic [127:0] ra,
  input  logic [7:0]   rb_cnt,   // rb bits 24..31 (preferred-slot low byte)
  input  logic [4:0]   i7_cnt,   // I7 bits 2..6
  output logic [127:0] result
);

  function automatic logic [127:0] shl_bytes(input logic [127:0] x, input logic [4:0] n);
    return (n >= 5'd16) ? '0 : (x << {n, 3'b000});
  endfunction

  // A shift by 128 yields zero, which makes the n = 0 case fall out naturally.
  function automatic logic [127:0] rotl(input logic [127:0] x, input logic [6:0] n);
    return (x << n) | (x >> (8'd128 - {1'b0, n}));
  endfunction

  always_comb begin
    result = '0;
    case (op)
      SHLQBI:   result = ra << rb_cnt[2:0];
      SHLQBII:  result = ra << i7_cnt[2:0];
      SHLQBY:   result = shl_bytes(ra, rb_cnt[4:0]);
      SHLQBYI:  result = shl_bytes(ra, i7_cnt);
      SHLQBYBI: result = shl_bytes(ra, rb_cnt[7:3]);
      ROTQBY:   result = rotl(ra, {rb_cnt[3:0], 3'b000});
      ROTQBYI:  result = rotl(ra, {i7_cnt[3:0], 3'b000});
      ROTQBYBI: result = rotl(ra, {rb_cnt[6:3], 3'b000});
      ROTQBI:   result = rotl(ra, {4'd0, rb_cnt[2:0]});
      ROTQBII:  result = rotl(ra, {4'd0, i7_cnt[2:0]});
`ifdef ODD_GATHER_BITS_EN
      GBB: for (int i = 0; i < 16; i++) result[111-i] = ra[120-8*i];
      GBH: for (int i = 0; i < 8; i++)  result[103-i] = ra[112-16*i];
      GB:  for (int i = 0; i < 4; i++)  result[99-i]  = ra[96-32*i];
`endif
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/odd_pipe.sv
`timescale 1ns/1ps
// Odd execution pipe: permute, local-store and branch groups feeding a
// result shift register. Gather-bits ops are enabled by ODD_GATHER_BITS_EN.
module odd_pipe
  import descriptions::*;
#(
  parameter int LS_ADDR_W = 15,
  parameter int STAGES    = 7
)
(
  input  logic                 clock,
  input  logic                 reset,
  input  op_e                  op_input_op_code,
  input  logic [127:0]         ra_input,
  input  logic [127:0]         rb_input,
  input  logic [6:0]           rt_address_input,
  input  logic [6:0]           I7_input,
  input  logic [9:0]           I10_input,
  input  logic [15:0]          I16_input,
  input  logic [17:0]          I18_input,
  output logic [LS_ADDR_W-1:0] LS_address,
  input  logic [127:0]         LS_data_input,
  output logic [127:0]         LS_data_output,
  output logic                 LS_wrt_en,
  output logic [PKT_W-1:0]     fw_op_st_1,
  output logic [PKT_W-1:0]     fw_op_st_2,
  output logic [PKT_W-1:0]     fw_op_st_3,
  output logic [PKT_W-1:0]     fw_op_st_4,
  output logic [PKT_W-1:0]     fw_op_st_5,
  output logic [PKT_W-1:0]     fw_op_st_6,
  output logic [PKT_W-1:0]     fw_op_st_7,
  output logic                 branch_taken,
  input  logic [31:0]          PC_input,
  output logic [31:0]          PC_output
);

  function automatic pkt_t mk_pkt(input logic [127:0] res, input logic [6:0] rt,
                                  input logic wr, input logic [2:0] unit,
                                  input logic [3:0] lat);
    pkt_t p;
    p.result = res;
    p.rt     = rt;
    p.wr_en  = wr;
    p.unit   = unit;
    p.lat    = lat;
    return p;
  endfunction

  logic [127:0] perm_result;
  logic [31:0]  ra_w0;
  logic [31:0]  pc_plus4;
  logic [31:0]  br_rel;
  logic [31:0]  br_abs;
  logic [31:0]  ls_off_d;
  logic [31:0]  ls_off_a;
  logic [31:0]  ls_addr_full;
  logic [31:0]  br_target;
  logic [31:0]  npc_p0;
  logic         ls_store;
  logic         taken_p0;
  pkt_t         pkt_p0;
  pkt_t         pkt_pipe [1:STAGES];
  logic         unused_bits;

  odd_permute_unit u_permute (
    .op     (op_input_op_code),
    .ra     (ra_input),
    .rb_cnt (rb_input[103:96]),
    .i7_cnt (I7_input[4:0]),
    .result (perm_result)
  );

  assign ra_w0    = ra_input[127:96];
  assign pc_plus4 = PC_input + 32'd4;
  assign br_rel   = (PC_input + (sext16(I16_input) << 2)) & BR_MASK;
  assign br_abs   = (sext16(I16_input) << 2) & BR_MASK;
  assign ls_off_d = ra_w0 + (sext10(I10_input) << 4);
  assign ls_off_a = sext16(I16_input) << 2;

  // Stage 0: decode and compute the issue-cycle packet, LS drive and next PC.
  always_comb begin
    pkt_p0       = '0;
    ls_addr_full = '0;
    ls_store     = 1'b0;
    taken_p0     = 1'b0;
    br_target    = '0;
    case (op_input_op_code)
      SHLQBI, SHLQBII, SHLQBY, SHLQBYI, SHLQBYBI,
      ROTQBY, ROTQBYI, ROTQBYBI, ROTQBI, ROTQBII:
        pkt_p0 = mk_pkt(perm_result, rt_address_input, 1'b1, UNIT_PERM, LAT_PERM);
`ifdef ODD_GATHER_BITS_EN
      GBB, GBH, GB:
        pkt_p0 = mk_pkt(perm_result, rt_address_input, 1'b1, UNIT_PERM, LAT_PERM);
`endif
      LQD: begin
        ls_addr_full = ls_off_d;
        pkt_p0 = mk_pkt(LS_data_input, rt_address_input, 1'b1, UNIT_LS, LAT_LS);
      end
      LQA: begin
        ls_addr_full = ls_off_a;
        pkt_p0 = mk_pkt(LS_data_input, rt_address_input, 1'b1, UNIT_LS, LAT_LS);
      end
      STQD: begin
        ls_addr_full = ls_off_d;
        ls_store     = 1'b1;
        pkt_p0 = mk_pkt('0, rt_address_input, 1'b0, UNIT_LS, LAT_LS);
      end
      STQA: begin
        ls_addr_full = ls_off_a;
        ls_store     = 1'b1;
        pkt_p0 = mk_pkt('0, rt_address_input, 1'b0, UNIT_LS, LAT_LS);
      end
      BR, BRA: begin
        br_target = (op_input_op_code == BR) ? br_rel : br_abs;
        taken_p0  = 1'b1;
        pkt_p0 = mk_pkt('0, rt_address_input, 1'b0, UNIT_BR, LAT_BR);
      end
      BRSL, BRASL: begin
        br_target = (op_input_op_code == BRSL) ? br_rel : br_abs;
        taken_p0  = 1'b1;
        pkt_p0 = mk_pkt({pc_plus4, 96'd0}, rt_address_input, 1'b1, UNIT_BR, LAT_BR);
      end
      BRZ, BRNZ, BRHZ, BRHNZ: begin
        br_target = br_rel;
        case (op_input_op_code)
          BRZ:     taken_p0 = (ra_w0 == 32'd0);
          BRNZ:    taken_p0 = (ra_w0 != 32'd0);
          BRHZ:    taken_p0 = (ra_w0[15:0] == 16'd0);
          default: taken_p0 = (ra_w0[15:0] != 16'd0);
        endcase
        pkt_p0 = mk_pkt('0, rt_address_input, 1'b0, UNIT_BR, LAT_BR);
      end
      default: pkt_p0 = '0;
    endcase
  end

  assign npc_p0         = taken_p0 ? br_target : pc_plus4;
  assign LS_address     = ls_addr_full[LS_ADDR_W-1:0] & LS_MASK[LS_ADDR_W-1:0];
  assign LS_wrt_en      = ls_store & reset;
  assign LS_data_output = ls_store ? rb_input : '0;

  // Stages 1..STAGES: result shift register, plus registered next PC.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 1; k <= STAGES; k++) pkt_pipe[k] <= '0;
      PC_output    <= '0;
      branch_taken <= 1'b0;
    end else begin
      pkt_pipe[1] <= pkt_p0;
      for (int k = 2; k <= STAGES; k++) pkt_pipe[k] <= pkt_pipe[k-1];
      PC_output    <= npc_p0;
      branch_taken <= taken_p0;
    end
  end

  assign fw_op_st_1 = pkt_pipe[1];
  assign fw_op_st_2 = pkt_pipe[2];
  assign fw_op_st_3 = pkt_pipe[3];
  assign fw_op_st_4 = pkt_pipe[4];
  assign fw_op_st_5 = pkt_pipe[5];
  assign fw_op_st_6 = pkt_pipe[6];
  assign fw_op_st_7 = pkt_pipe[7];

  assign unused_bits = ^{I18_input, I7_input[6:5], ls_addr_full[31:LS_ADDR_W],
                         UNIT_NONE};

endmodule

// File: tb/tb_odd_pipe.sv
`timescale 1ns/1ps
// Directed and randomized bench for odd_pipe against a behavioural model.
module tb_odd_pipe;
  import descriptions::*;

  logic         clock = 1'b0;
  logic         reset;
  op_e          op_input_op_code;
  logic [127:0] ra_input, rb_input, LS_data_input, LS_data_output;
  logic [6:0]   rt_address_input, I7_input;
  logic [9:0]   I10_input;
  logic [15:0]  I16_input;
  logic [17:0]  I18_input;
  logic [14:0]  LS_address;
  logic         LS_wrt_en, branch_taken;
  logic [142:0] fw_op_st_1, fw_op_st_2, fw_op_st_3, fw_op_st_4;
  logic [142:0] fw_op_st_5, fw_op_st_6, fw_op_st_7;
  logic [31:0]  PC_input, PC_output;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [142:0] hist [$];

  always #5 clock = ~clock;

  odd_pipe dut (
    .clock(clock), .reset(reset), .op_input_op_code(op_input_op_code),
    .ra_input(ra_input), .rb_input(rb_input), .rt_address_input(rt_address_input),
    .I7_input(I7_input), .I10_input(I10_input), .I16_input(I16_input),
    .I18_input(I18_input), .LS_address(LS_address), .LS_data_input(LS_data_input),
    .LS_data_output(LS_data_output), .LS_wrt_en(LS_wrt_en),
    .fw_op_st_1(fw_op_st_1), .fw_op_st_2(fw_op_st_2), .fw_op_st_3(fw_op_st_3),
    .fw_op_st_4(fw_op_st_4), .fw_op_st_5(fw_op_st_5), .fw_op_st_6(fw_op_st_6),
    .fw_op_st_7(fw_op_st_7), .branch_taken(branch_taken),
    .PC_input(PC_input), .PC_output(PC_output)
  );

  typedef struct packed {
    logic [142:0] pkt;
    logic [14:0]  addr;
    logic         is_mem;
    logic         we_ls;
    logic [31:0]  npc;
    logic         taken;
  } exp_t;

  function automatic logic [127:0] rot_left(input logic [127:0] x, input int n);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[(i + n) % 128] = x[i];
    return r;
  endfunction

  function automatic logic [127:0] byte_shl(input logic [127:0] x, input int n);
    return (n >= 16) ? 128'd0 : (x << (8 * n));
  endfunction

  // LSB of each of `count` equal-sized elements, first element (most significant) first.
  function automatic logic [31:0] gather(input logic [127:0] x, input int count);
    logic [31:0]  g = 0;
    logic [127:0] t;
    int bits = 128 / count;
    for (int e = 0; e < count; e++) begin
      t = x >> (bits * (count - 1 - e));
      g = (g << 1) | {31'd0, t[0]};
    end
    return g;
  endfunction

  function automatic exp_t model(input op_e o, input logic [127:0] ra, rb,
                                 input logic [6:0] rt, i7, input logic [9:0] i10,
                                 input logic [15:0] i16, input logic [31:0] pc,
                                 input logic [127:0] lsd);
    exp_t e;
    logic [127:0] res;
    logic [31:0] ra0, rb0, a32, rel, abso;
    int s10, s16, ib;
    logic wr;
    logic [2:0] unit;
    logic [3:0] lat;
    e = '0; res = '0; wr = 0; unit = 0; lat = 0;
    ra0 = ra[127:96]; rb0 = rb[127:96];
    ib = int'(i7);
    s10 = $signed(i10); s16 = $signed(i16);
    rel = (pc + s16 * 4) & 32'h7FFC;
    abso = (s16 * 4) & 32'h7FFC;
    e.npc = pc + 4;
    a32 = 0;
    case (o)
      SHLQBI:   begin res = ra << (rb0 % 8);                      unit = 1; end
      SHLQBII:  begin res = ra << (ib % 8);                       unit = 1; end
      SHLQBY:   begin res = byte_shl(ra, rb0 % 32);               unit = 1; end
      SHLQBYI:  begin res = byte_shl(ra, ib % 32);                unit = 1; end
      SHLQBYBI: begin res = byte_shl(ra, (rb0 / 8) % 32);         unit = 1; end
      ROTQBY:   begin res = rot_left(ra, 8 * (rb0 % 16));         unit = 1; end
      ROTQBYI:  begin res = rot_left(ra, 8 * (ib % 16));          unit = 1; end
      ROTQBYBI: begin res = rot_left(ra, 8 * ((rb0 / 8) % 16));   unit = 1; end
      ROTQBI:   begin res = rot_left(ra, rb0 % 8);                unit = 1; end
      ROTQBII:  begin res = rot_left(ra, ib % 8);                 unit = 1; end
`ifdef ODD_GATHER_BITS_EN
      GBB: begin res = {gather(ra, 16), 96'd0}; unit = 1; end
      GBH: begin res = {gather(ra, 8), 96'd0};  unit = 1; end
      GB:  begin res = {gather(ra, 4), 96'd0};  unit = 1; end
`endif
      LQD, STQD: begin a32 = ra0 + s10 * 16; unit = 2; end
      LQA, STQA: begin a32 = s16 * 4;        unit = 2; end
      BR:    begin e.taken = 1; e.npc = rel;  unit = 3; end
      BRA:   begin e.taken = 1; e.npc = abso; unit = 3; end
      BRSL:  begin e.taken = 1; e.npc = rel;  unit = 3; res = {pc + 32'd4, 96'd0}; end
      BRASL: begin e.taken = 1; e.npc = abso; unit = 3; res = {pc + 32'd4, 96'd0}; end
      BRZ:   begin e.taken = (ra0 == 0);         unit = 3; end
      BRNZ:  begin e.taken = (ra0 != 0);         unit = 3; end
      BRHZ:  begin e.taken = (ra0 % 65536 == 0); unit = 3; end
      BRHNZ: begin e.taken = (ra0 % 65536 != 0); unit = 3; end
      default: ;
    endcase
    if (o inside {BRZ, BRNZ, BRHZ, BRHNZ} && e.taken) e.npc = rel;
    if (unit == 1) begin wr = 1; lat = 4; end
    if (unit == 2) begin
      lat = 6; e.is_mem = 1;
      e.addr = a32[14:0] & 15'h7FF0;
      if (o inside {LQD, LQA}) begin wr = 1; res = lsd; end
      else e.we_ls = 1;
    end
    if (unit == 3) begin lat = 1; wr = o inside {BRSL, BRASL}; end
    e.pkt = (unit == 0) ? 143'd0 : {res, rt, wr, unit, lat};
    return e;
  endfunction

  function automatic logic [142:0] fw(input int k);
    case (k)
      1: return fw_op_st_1;
      2: return fw_op_st_2;
      3: return fw_op_st_3;
      4: return fw_op_st_4;
      5: return fw_op_st_5;
      6: return fw_op_st_6;
      default: return fw_op_st_7;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [142:0] obs, input logic [142:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_stages(input string tag);
    for (int k = 1; k <= 7; k++)
      check($sformatf("%s_st%0d", tag, k), fw(k), (k <= hist.size()) ? hist[k-1] : 143'd0);
  endtask

  // Called at a negedge: drives one instruction, checks LS outputs, clocks, checks regs.
  task automatic issue(input string tag, input op_e o, input logic [127:0] a, b,
                       input logic [6:0] rt, i7, input logic [9:0] i10,
                       input logic [15:0] i16, input logic [31:0] pc);
    exp_t e;
    logic [127:0] lsd;
    lsd = rnd128();
    op_input_op_code = o; ra_input = a; rb_input = b; rt_address_input = rt;
    I7_input = i7; I10_input = i10; I16_input = i16; I18_input = 18'($urandom);
    PC_input = pc; LS_data_input = lsd;
    e = model(o, a, b, rt, i7, i10, i16, pc, lsd);
    #1;
    if (e.is_mem) check({tag, "_addr"}, LS_address, e.addr);
    check({tag, "_wen"}, LS_wrt_en, e.we_ls);
    if (e.we_ls) check({tag, "_sdata"}, LS_data_output, b);
    @(posedge clock);
    hist.push_front(e.pkt);
    if (hist.size() > 7) void'(hist.pop_back());
    @(negedge clock);
    check_stages(tag);
    check({tag, "_pc"}, PC_output, e.npc);
    check({tag, "_taken"}, branch_taken, e.taken);
  endtask

  initial begin
    op_e o;
    logic [127:0] a, b;
    reset = 1'b0;
    op_input_op_code = STQA; ra_input = '0; rb_input = 128'd7; rt_address_input = '0;
    I7_input = '0; I10_input = '0; I16_input = 16'd4; I18_input = '0;
    PC_input = 32'd100; LS_data_input = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_wen", LS_wrt_en, 1'b0);
    check_stages("rst");
    check("rst_pc", PC_output, 32'd0);
    check("rst_taken", branch_taken, 1'b0);
    reset = 1'b1;

    issue("shlqbi", SHLQBI, 128'd20, {32'd10, 96'd0}, 7'd5, 7'd0, 10'd0, 16'd0, 32'd0);
    check("shlqbi_res80", fw_op_st_1[142:15], 128'd80);
    check("shlqbi_we", fw_op_st_1[7], 1'b1);
    issue("shlqbyi", SHLQBYI, 128'd33, '0, 7'd6, 7'd15, 10'd0, 16'd0, 32'd4);
    check("shlqbyi_res", fw_op_st_1[142:15], 128'd33 << 120);
    issue("rotqbyi", ROTQBYI, 128'd37, '0, 7'd7, 7'd7, 10'd0, 16'd0, 32'd8);
    issue("gbb", GBB, 128'd15, '0, 7'd8, 7'd0, 10'd0, 16'd0, 32'd12);
    issue("gbh", GBH, 128'd95, '0, 7'd9, 7'd0, 10'd0, 16'd0, 32'd16);
    issue("gb", GB, 128'd45, '0, 7'd10, 7'd0, 10'd0, 16'd0, 32'd20);
    issue("lqd", LQD, {32'd5, 96'd0}, '0, 7'd11, 7'd0, 10'd5, 16'd0, 32'd24);
    check("shlqbi_at_st7", fw_op_st_7[142:15], 128'd80);
    issue("stqa", STQA, '0, 128'd3, 7'd12, 7'd0, 10'd0, 16'd18, 32'd28);
    issue("br", BR, '0, '0, 7'd0, 7'd0, 10'd0, 16'd3, 32'd162);
    check("br_pc172", PC_output, 32'd172);
    issue("brz", BRZ, '0, '0, 7'd0, 7'd0, 10'd0, 16'd38, 32'd21);
    issue("brhnz", BRHNZ, '0, '0, 7'd0, 7'd0, 10'd0, 16'd38, 32'd22);
    check("brhnz_pc26", PC_output, 32'd26);
    issue("brsl", BRSL, '0, '0, 7'd3, 7'd0, 10'd0, 16'hFFFE, 32'd400);
    issue("unknown", op_e'(6'd40), rnd128(), rnd128(), 7'd4, 7'd1, 10'd1, 16'd1, 32'd44);
    issue("lqd_wrap", LQD, '0, '0, 7'd13, 7'd0, 10'h3FF, 16'd0, 32'd48);
    issue("shlqby_big", SHLQBY, rnd128(), {32'd17, 96'd0}, 7'd14, 7'd0, 10'd0, 16'd0, 32'd52);

    for (int t = 0; t < 300; t++) begin
      o = op_e'($urandom_range(0, 26));
      a = rnd128();
      if ($urandom_range(0, 2) == 0) a[127:96] = '0;
      else if ($urandom_range(0, 1) == 0) a[111:96] = '0;
      b = rnd128();
      if ($urandom_range(0, 1) == 0) b[127:96] = 32'($urandom_range(0, 255));
      issue($sformatf("rnd%0d", t), o, a, b, 7'($urandom), 7'($urandom), 10'($urandom),
            16'($urandom), $urandom & 32'hFFFF);
    end

    reset = 1'b0;
    op_input_op_code = STQD; rb_input = rnd128();
    #1;
    check("midrst_wen", LS_wrt_en, 1'b0);
    @(posedge clock);
    hist.delete();
    @(negedge clock);
    check_stages("midrst");
    check("midrst_pc", PC_output, 32'd0);
    check("midrst_taken", branch_taken, 1'b0);
    reset = 1'b1;

    for (int t = 0; t < 20; t++)
      issue($sformatf("post%0d", t), op_e'($urandom_range(0, 25)), rnd128(), rnd128(),
            7'($urandom), 7'($urandom), 10'($urandom), 16'($urandom), $urandom & 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
